// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the Execute stage.
// Produces one result bit per cycle and stalls the front end while it works.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  assign accept = start & ~flush & (state_q != S_RUN);

  // The multiplier sits in the low half of acc and is consumed from bit 0 as the
  // partial product shifts right; the divide step borrows from the top bit of the
  // trial subtraction, so a clear borrow means the divisor fit.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    rem_step  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          rem_d = rem_step;
          quo_d = quo_step;
        end else begin
          acc_d = acc_step;
        end
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:   result_d = acc_step[WIDTH-1:0];
            OP_MULHU: result_d = acc_step[2*WIDTH-1:WIDTH];
            OP_DIVU:  result_d = quo_step;
            default:  result_d = rem_step;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Division by zero skips iteration entirely and completes next cycle.
    if (accept) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      cnt_d = '0;
      dbz_d = 1'b0;
      if (op[1] && (b == '0)) begin
        quo_d    = '1;
        rem_d    = a;
        result_d = (op == OP_DIVU) ? {WIDTH{1'b1}} : a;
        dbz_d    = 1'b1;
        state_d  = S_DONE;
      end else if (op[1]) begin
        rem_d   = '0;
        quo_d   = a;
        state_d = S_RUN;
      end else begin
        acc_d   = {{WIDTH{1'b0}}, b};
        state_d = S_RUN;
      end
    end

    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      dbz_d    = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Stall drops on the done cycle unless a new operation is taken, letting the pipe advance.
  assign busy        = (state_q == S_RUN) | ((state_q == S_DONE) & start);
  assign stall       = (start & ~flush & (state_q != S_RUN)) | (state_q == S_RUN);
  assign done        = (state_q == S_DONE) & ~flush & ~rst;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an arithmetic reference model tracks
// expected outputs every cycle, and directed cases pin known literal results.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  result;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  int            mRunLeft = 0;
  logic          mDone = 1'b0;
  logic [W-1:0]  mPending = '0;
  logic [W-1:0]  mResult = '0;
  logic          mDbz = 1'b0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Plain arithmetic answer for one operation.
  function automatic logic [W-1:0] refCompute(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: an accepted op takes W cycles (or none for a zero divisor)
  // and its result becomes visible together with the done pulse.
  always @(posedge clk) begin
    if (rst) begin
      mRunLeft <= 0;
      mDone    <= 1'b0;
      mResult  <= '0;
      mDbz     <= 1'b0;
    end else if (flush) begin
      mRunLeft <= 0;
      mDone    <= 1'b0;
    end else if (start && mRunLeft == 0) begin
      mDbz <= op[1] && (b == 0);
      if (op[1] && (b == 0)) begin
        mResult  <= refCompute(op, a, b);
        mDone    <= 1'b1;
        mRunLeft <= 0;
      end else begin
        mPending <= refCompute(op, a, b);
        mRunLeft <= W;
        mDone    <= 1'b0;
      end
    end else if (mRunLeft > 0) begin
      mRunLeft <= mRunLeft - 1;
      if (mRunLeft == 1) begin
        mDone   <= 1'b1;
        mResult <= mPending;
      end
    end else begin
      mDone <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, (mRunLeft > 0) || (mDone && start)});
      checkOutput("stall", {31'b0, stall}, {31'b0, (mRunLeft > 0) || (start && !flush)});
      checkOutput("done", {31'b0, done}, {31'b0, mDone && !flush && !rst});
      checkOutput("result", result, mResult);
      checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, mDbz});
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Entered one cycle after the start cycle; returns at the falling edge of the done cycle.
  task automatic waitForDone(input bit noise, output int lat, output logic [W-1:0] res,
                             output logic dz);
    lat = 1;
    res = '0;
    dz  = 1'b0;
    while (lat <= 80) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      start = (noise && mRunLeft > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (done) begin
        res = result;
        dz  = div_by_zero;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic runDirected(input string name, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input bit noise, input logic [W-1:0] expRes,
                             input logic expDz, input int expLat);
    int lat;
    logic [W-1:0] res;
    logic dz;
    applyStimulus(o, x, y);
    waitForDone(noise, lat, res, dz);
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_result"}, res, expRes);
    checkOutput({name, "_dbz"}, {31'b0, dz}, {31'b0, expDz});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nDone;
    int lat;
    logic [W-1:0] res;
    logic dz;
    logic [1:0] ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    rst = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;

    @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;

    runDirected("mul_7x6", 2'b00, 32'd7, 32'd6, 1'b0, 32'd42, 1'b0, 33);
    runDirected("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 33);
    runDirected("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 33);
    runDirected("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 33);
    runDirected("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0, 33);
    runDirected("divu_msb_1", 2'b10, 32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 33);
    runDirected("divu_5_0", 2'b10, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1);
    runDirected("remu_5_0", 2'b11, 32'd5, 32'd0, 1'b0, 32'd5, 1'b1, 1);
    runDirected("mul_3x5", 2'b00, 32'd3, 32'd5, 1'b0, 32'd15, 1'b0, 33);

    // Flush while the iteration counter reads 10.
    applyStimulus(2'b00, 32'd123, 32'd456);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_stall", {31'b0, stall}, 32'd0);
    checkOutput("flush_result", result, 32'd15);
    nDone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nDone++;
    end
    checkOutput("flush_no_done", nDone, 32'd0);
    @(posedge clk);
    #1;
    runDirected("after_flush", 2'b00, 32'd123, 32'd456, 1'b0, 32'd56088, 1'b0, 33);

    // Back-to-back: a new start on the done cycle.
    applyStimulus(2'b10, 32'd1000, 32'd3);
    repeat (32) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op = 2'b11;
    a = 32'd1000;
    b = 32'd3;
    @(negedge clk);
    checkOutput("b2b_first_done", {31'b0, done}, 32'd1);
    checkOutput("b2b_first_result", result, 32'd333);
    checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitForDone(1'b0, lat, res, dz);
    checkOutput("b2b_second_latency", lat, 32'd33);
    checkOutput("b2b_second_result", res, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = '0;
        1:       ry = 32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      applyStimulus(ro, rx, ry);
      waitForDone(1'b1, lat, res, dz);
      checkOutput("rand_latency", lat, (ro[1] && ry == 0) ? 32'd1 : 32'd33);
      checkOutput("rand_result", res, refCompute(ro, rx, ry));
      @(posedge clk);
      #1;
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
